thermometer_ramp_ctrl: RTL and testbench

//  Rate-limited sequencer for the binary-to-thermometer datapath.

---
 rtl/thermometer_ramp_if.sv | 21 ++
 rtl/thermometer_ramp_ctrl.sv | 105 ++++++++++
 tb/tb_thermometer_ramp_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/thermometer_ramp_if.sv
// Target-code handshake between a code source and the ramp controller.
// The master offers tgt_code with tgt_valid; the slave answers with tgt_ready.
interface thermometer_ramp_if #(
   parameter int WIDTH = 8
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_code;

   modport master (
      output tgt_valid,
      output tgt_code,
      input  tgt_ready
   );

   modport slave (
      input  tgt_valid,
      input  tgt_code,
      output tgt_ready
   );
endinterface

// File: rtl/thermometer_ramp_ctrl.sv
// Rate-limited ramp sequencer: steps a binary code 1 LSB per STEP_DIV
// cycles toward an accepted target and drives its thermometer expansion.
module thermometer_ramp_ctrl #(
   parameter int WIDTH    = 8,
   parameter int STEP_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   thermometer_ramp_if.slave     tgt,
   input  logic                  hold,
   output logic [WIDTH-1:0]      cur_code,
   output logic [2**WIDTH-1:0]   therm_out,
   output logic                  busy,
   output logic                  done
);
   localparam int THERM_W = 2**WIDTH;
   localparam int DW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

   if (STEP_DIV < 1) begin : g_bad_div
      $error("thermometer_ramp_ctrl: STEP_DIV must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      DONE
   } state_e;

   state_e               state_q;
   logic [WIDTH-1:0]     cur_q, cur_d;
   logic [WIDTH-1:0]     tgt_q;
   logic [DW-1:0]        div_q;
   logic [THERM_W-1:0]   therm_q, therm_d;
   logic                 busy_q;
   logic                 done_q;
   logic                 step;

   assign tgt.tgt_ready = rst_n & (state_q == IDLE);
   assign cur_code      = cur_q;
   assign therm_out     = therm_q;
   assign busy          = busy_q;
   assign done          = done_q;

   // A step only happens while the code still differs from the target.
   assign step = (state_q == RAMP) && (cur_q != tgt_q) &&
                 !hold && (div_q == LAST);

   always_comb begin
      cur_d   = cur_q;
      therm_d = '0;
      if (step) begin
         cur_d = (tgt_q > cur_q) ? cur_q + WIDTH'(1) : cur_q - WIDTH'(1);
      end
      for (int i = 0; i < THERM_W; i++) begin
         therm_d[i] = (i < int'(cur_d));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         div_q   <= '0;
         therm_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         cur_q   <= cur_d;
         therm_q <= therm_d;
         unique case (state_q)
            IDLE: begin
               if (tgt.tgt_valid) begin
                  tgt_q <= tgt.tgt_code;
                  div_q <= '0;
                  if (tgt.tgt_code == cur_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RAMP;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RAMP: begin
               if (cur_q == tgt_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (!hold) begin
                  div_q <= (div_q == LAST) ? '0 : div_q + DW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_thermometer_ramp_ctrl.sv
// Bench for thermometer_ramp_ctrl: directed ramps plus random targets/holds
// checked against a trajectory model derived from the ramp timing rules.
module tb_thermometer_ramp_ctrl;
   localparam int W  = 8;
   localparam int TW = 256;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hold;
   logic [W-1:0]  cur, cur2;
   logic [TW-1:0] therm, therm2;
   logic          busy, busy2, done, done2;
   logic          hold2 = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int mcode = 0;
   int edges;

   thermometer_ramp_if #(.WIDTH(W)) bus ();
   thermometer_ramp_if #(.WIDTH(W)) bus2 ();

   thermometer_ramp_ctrl #(.WIDTH(W), .STEP_DIV(SD)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt       (bus.slave),
      .hold      (hold),
      .cur_code  (cur),
      .therm_out (therm),
      .busy      (busy),
      .done      (done)
   );

   thermometer_ramp_ctrl #(.WIDTH(W), .STEP_DIV(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt       (bus2.slave),
      .hold      (hold2),
      .cur_code  (cur2),
      .therm_out (therm2),
      .busy      (busy2),
      .done      (done2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TW-1:0] got,
                      input logic [TW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] therm_of(input int code);
      logic [TW-1:0] r;
      for (int i = 0; i < TW; i++) r[i] = (i < code);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer target t, then follow the ramp cycle by cycle. The expected code
   // is start +/- (non-held edges)/SD, capped at the distance.
   task automatic do_ramp(input int t, input int hold_pct, input bit pulses,
                          input int h_at, input int h_len, output int n_edges);
      int c, d, dir, eff, j, e, pe;
      logic [TW-1:0] prev;
      bit h;
      c   = mcode;
      d   = (t > c) ? t - c : c - t;
      dir = (t > c) ? 1 : -1;
      chk("ready_idle", TW'(bus.tgt_ready), 1);
      bus.tgt_valid = 1'b1;
      bus.tgt_code  = W'(t);
      hold = 1'($urandom_range(0, 1));
      tick();
      bus.tgt_valid = 1'b0;
      j = 1; eff = 0; pe = c; prev = therm_of(c);
      if (d > 0) begin
         while (eff < d * SD) begin
            e = c + dir * (eff / SD);
            chk("cur", TW'(cur), TW'(e));
            chk("therm", therm, therm_of(e));
            chk("flip", TW'($countones(therm ^ prev)), (e != pe) ? 1 : 0);
            chk("busy", TW'(busy), 1);
            chk("done_ramp", TW'(done), 0);
            chk("rdy_ramp", TW'(bus.tgt_ready), 0);
            prev = therm; pe = e;
            h = (j > h_at && j <= h_at + h_len) ||
                ($urandom_range(0, 99) < hold_pct);
            hold = h;
            if (pulses) begin
               bus.tgt_valid = 1'($urandom_range(0, 1));
               bus.tgt_code  = W'($urandom);
            end
            tick();
            j++;
            if (!h) eff++;
            if (j > d * SD + 2000) begin
               chk("timeout", 1, 0);
               break;
            end
         end
         chk("cur_end", TW'(cur), TW'(t));
         chk("flip_end", TW'($countones(therm ^ prev)), 1);
         chk("busy_end", TW'(busy), 1);
         chk("done_early", TW'(done), 0);
         bus.tgt_valid = 1'b0;
         hold = 1'($urandom_range(0, 1));
         tick();
      end else begin
         j = 0;
      end
      chk("cur_done", TW'(cur), TW'(t));
      chk("therm_done", therm, therm_of(t));
      chk("done", TW'(done), 1);
      chk("busy_done", TW'(busy), 0);
      chk("rdy_done", TW'(bus.tgt_ready), 0);
      hold = 1'b0;
      tick();
      chk("done_pulse", TW'(done), 0);
      chk("rdy_back", TW'(bus.tgt_ready), 1);
      n_edges = j;
      mcode = t;
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      hold = 1'b0;
      bus.tgt_valid = 1'b0;
      bus.tgt_code = '0;
      bus2.tgt_valid = 1'b0;
      bus2.tgt_code = '0;
      #12;
      chk("rst_cur", TW'(cur), 0);
      chk("rst_therm", therm, 0);
      chk("rst_busy", TW'(busy), 0);
      chk("rst_done", TW'(done), 0);
      chk("rst_rdy", TW'(bus.tgt_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      do_ramp(3, 0, 0, 0, 0, edges);
      chk("lat_3", TW'(edges), 3 * SD + 1);
      chk("therm_3", therm, 256'h7);
      do_ramp(17, 0, 0, 0, 0, edges);
      do_ramp(17, 0, 0, 0, 0, edges);
      chk("lat_eq", TW'(edges), 0);
      do_ramp(0, 0, 0, 0, 0, edges);
      do_ramp(255, 0, 0, 0, 0, edges);
      chk("lat_255", TW'(edges), 255 * SD + 1);
      chk("therm_255", therm, {1'b0, {255{1'b1}}});
      do_ramp(1, 0, 1, 0, 0, edges);
      chk("therm_1", therm, 256'h1);

      for (int k = 0; k < 6; k++) begin
         t = mcode + $urandom_range(0, 60) - 30;
         if (t < 0) t = 0;
         if (t > 255) t = 255;
         do_ramp(t, 20, 1, 0, 0, edges);
      end

      do_ramp(0, 0, 0, 0, 0, edges);
      do_ramp(10, 0, 0, 13, 7, edges);
      chk("lat_hold", TW'(edges), 10 * SD + 7 + 1);

      bus.tgt_valid = 1'b1;
      bus.tgt_code = 8'd200;
      tick();
      bus.tgt_valid = 1'b0;
      for (int k = 0; k < 1000 && cur != 8'd100; k++) tick();
      chk("reach_100", TW'(cur), 100);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cur", TW'(cur), 0);
      chk("arst_therm", therm, 0);
      chk("arst_rdy", TW'(bus.tgt_ready), 0);
      chk("arst_busy", TW'(busy), 0);
      repeat (2) begin
         tick();
         chk("arst_done", TW'(done), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      mcode = 0;
      do_ramp(2, 0, 0, 0, 0, edges);
      chk("lat_2", TW'(edges), 2 * SD + 1);

      bus2.tgt_valid = 1'b1;
      bus2.tgt_code = 8'd5;
      tick();
      bus2.tgt_valid = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         chk("div1_cur", TW'(cur2), TW'(n));
      end
      chk("div1_therm", therm2, 256'h1f);
      tick();
      chk("div1_done", TW'(done2), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
